// File: rtl/iter_divider.sv
// iter_divider: multicycle signed restoring divider for the execute stage.
// Quotient truncates toward zero and the remainder takes the dividend's sign.
// A zero divisor finishes one edge after start with div_by_zero raised.
// Optional macro ITER_DIVIDER_OVF_EXC_EN adds an ovf port. With it, the
// -2^(WIDTH-1) / -1 case also finishes one edge after start.
module iter_divider #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned CNT_W = 6
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero,
    output logic             busy,
`ifdef ITER_DIVIDER_OVF_EXC_EN
    output logic             ovf,
`endif
    output logic             result_rdy
);

    localparam logic [WIDTH-1:0] MIN_VAL = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIX  = 2'd2
    } state_e;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] q_q, q_d;         // dividend magnitude shifting into the quotient
    logic [WIDTH-1:0] rem_q, rem_d;     // partial remainder
    logic [WIDTH:0]   dvs_q, dvs_d;     // divisor magnitude, one extra bit for -2^(W-1)
    logic             sgn_q_q, sgn_q_d;
    logic             sgn_r_q, sgn_r_d;
    logic             pend_q, pend_d;   // early completion scheduled for the next edge
    logic [WIDTH-1:0] quo_q, quo_d;
    logic [WIDTH-1:0] remo_q, remo_d;
    logic             dbz_q, dbz_d;
    logic             busy_q, busy_d;
    logic             rdy_q, rdy_d;
`ifdef ITER_DIVIDER_OVF_EXC_EN
    logic             pend_ovf_q, pend_ovf_d;
    logic             ovf_q, ovf_d;
`endif

    logic [WIDTH:0]   rem_sh;
    logic [WIDTH:0]   diff;
    logic [WIDTH:0]   dvs_ext;

    // State and datapath registers
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            q_q        <= '0;
            rem_q      <= '0;
            dvs_q      <= '0;
            sgn_q_q    <= 1'b0;
            sgn_r_q    <= 1'b0;
            pend_q     <= 1'b0;
            quo_q      <= '0;
            remo_q     <= '0;
            dbz_q      <= 1'b0;
            busy_q     <= 1'b0;
            rdy_q      <= 1'b0;
`ifdef ITER_DIVIDER_OVF_EXC_EN
            pend_ovf_q <= 1'b0;
            ovf_q      <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            q_q        <= q_d;
            rem_q      <= rem_d;
            dvs_q      <= dvs_d;
            sgn_q_q    <= sgn_q_d;
            sgn_r_q    <= sgn_r_d;
            pend_q     <= pend_d;
            quo_q      <= quo_d;
            remo_q     <= remo_d;
            dbz_q      <= dbz_d;
            busy_q     <= busy_d;
            rdy_q      <= rdy_d;
`ifdef ITER_DIVIDER_OVF_EXC_EN
            pend_ovf_q <= pend_ovf_d;
            ovf_q      <= ovf_d;
`endif
        end
    end

    // Next-state, one restoring step per RUN cycle, and result formatting
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        q_d        = q_q;
        rem_d      = rem_q;
        dvs_d      = dvs_q;
        sgn_q_d    = sgn_q_q;
        sgn_r_d    = sgn_r_q;
        pend_d     = 1'b0;
        quo_d      = quo_q;
        remo_d     = remo_q;
        dbz_d      = 1'b0;
        busy_d     = busy_q;
        rdy_d      = 1'b0;
`ifdef ITER_DIVIDER_OVF_EXC_EN
        pend_ovf_d = 1'b0;
        ovf_d      = 1'b0;
`endif
        rem_sh  = {rem_q, q_q[WIDTH-1]};
        diff    = rem_sh - dvs_q;
        dvs_ext = {divisor[WIDTH-1], divisor};

        case (state_q)
            IDLE: begin
                // Publish an early completion scheduled by the previous start
                if (pend_q) begin
                    rdy_d = 1'b1;
`ifdef ITER_DIVIDER_OVF_EXC_EN
                    if (pend_ovf_q) begin
                        ovf_d  = 1'b1;
                        quo_d  = MIN_VAL;
                        remo_d = '0;
                    end else begin
                        dbz_d  = 1'b1;
                        quo_d  = '0;
                        remo_d = q_q;
                    end
`else
                    dbz_d  = 1'b1;
                    quo_d  = '0;
                    remo_d = q_q;
`endif
                end
                if (start) begin
                    sgn_q_d = dividend[WIDTH-1] ^ divisor[WIDTH-1];
                    sgn_r_d = dividend[WIDTH-1];
                    q_d     = dividend[WIDTH-1] ? -dividend : dividend;
                    dvs_d   = divisor[WIDTH-1] ? -dvs_ext : dvs_ext;
                    rem_d   = '0;
                    if (divisor == '0) begin
                        // Raw dividend is kept in q for the remainder output
                        pend_d = 1'b1;
                        q_d    = dividend;
`ifdef ITER_DIVIDER_OVF_EXC_EN
                    end else if (dividend == MIN_VAL && divisor == '1) begin
                        pend_d     = 1'b1;
                        pend_ovf_d = 1'b1;
`endif
                    end else begin
                        state_d = RUN;
                        cnt_d   = '0;
                        busy_d  = 1'b1;
                    end
                end
            end
            RUN: begin
                if (!diff[WIDTH]) begin
                    rem_d = diff[WIDTH-1:0];
                    q_d   = {q_q[WIDTH-2:0], 1'b1};
                end else begin
                    rem_d = rem_sh[WIDTH-1:0];
                    q_d   = {q_q[WIDTH-2:0], 1'b0};
                end
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == LAST_STEP) begin
                    state_d = FIX;
                end
            end
            FIX: begin
                quo_d   = sgn_q_q ? -q_q : q_q;
                remo_d  = sgn_r_q ? -rem_q : rem_q;
                rdy_d   = 1'b1;
                busy_d  = 1'b0;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    assign quotient    = quo_q;
    assign remainder   = remo_q;
    assign div_by_zero = dbz_q;
    assign busy        = busy_q;
    assign result_rdy  = rdy_q;
`ifdef ITER_DIVIDER_OVF_EXC_EN
    assign ovf         = ovf_q;
`endif

endmodule
